// File: rtl/bcd_to_bin_conv.sv
// BCD-to-binary converter using reverse double-dabble, one shift per clock.
// Ports: CLK, RST_N, START, BCDIN in; BIN, DONE, BUSY, OVF, ERR out.
module bcd_to_bin_conv #(
  parameter int NDIG  = 4,
  parameter int OUT_W = 11
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [4*NDIG-1:0] BCDIN,
  output logic [OUT_W-1:0]  BIN,
  output logic              DONE,
  output logic              BUSY,
  output logic              OVF,
  output logic              ERR
);

  localparam int LW = 4 * NDIG;
  localparam int SW = 8 * NDIG;
  localparam int XW = (LW > OUT_W) ? LW : OUT_W;

  localparam logic [XW-1:0] MAXV = XW'({OUT_W{1'b1}});
  localparam logic [4:0]    LAST = 5'(LW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    sr_q, sr_d;
  logic [4:0]       itc_q, itc_d;
  logic             errf_q, errf_d;
  logic [OUT_W-1:0] bin_q, bin_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [SW-1:0]    sr_shift;
  logic [XW-1:0]    low_ext;
  logic             low_ovf;

  function automatic logic bad_digit(
    input logic [LW-1:0] v
  );
    logic b;
    b = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

  // Per-nibble correction, no carries across digits.
  function automatic logic [LW-1:0] fix_digits(
    input logic [LW-1:0] v
  );
    logic [LW-1:0] r;
    r = v;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i+3]) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

  assign sr_shift = sr_q >> 1;
  assign low_ext  = XW'(sr_q[LW-1:0]);
  assign low_ovf  = (low_ext > MAXV);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    itc_d   = itc_q;
    errf_d  = errf_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          sr_d  = {BCDIN, {LW{1'b0}}};
          itc_d = 5'd0;
          if (bad_digit(BCDIN)) begin
            errf_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            errf_d  = 1'b0;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        sr_d  = {fix_digits(sr_shift[SW-1:LW]),
                 sr_shift[LW-1:0]};
        itc_d = itc_q + 5'd1;
        if (itc_q == LAST) state_d = S_FIN;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (errf_q) begin
          bin_d = '0;
          ovf_d = 1'b0;
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
          ovf_d = low_ovf;
          bin_d = low_ovf ? {OUT_W{1'b1}}
                          : low_ext[OUT_W-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      itc_q   <= '0;
      errf_q  <= 1'b0;
      bin_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      itc_q   <= itc_d;
      errf_q  <= errf_d;
      bin_q   <= bin_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign BIN  = bin_q;
  assign DONE = done_q;
  assign OVF  = ovf_q;
  assign ERR  = err_q;
  assign BUSY = (state_q != S_IDLE);

endmodule

// File: tb/tb_bcd_to_bin_conv.sv
// Scoreboard bench for bcd_to_bin_conv: directed BCD vectors,
// expected results queued at START and checked on each DONE.
module tb_bcd_to_bin_conv;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [15:0] BCDIN;
  logic [10:0] BIN;
  logic        DONE;
  logic        BUSY;
  logic        OVF;
  logic        ERR;

  bcd_to_bin_conv #(
    .NDIG (4),
    .OUT_W(11)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .START(START),
    .BCDIN(BCDIN),
    .BIN  (BIN),
    .DONE (DONE),
    .BUSY (BUSY),
    .OVF  (OVF),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [10:0] bin;
    logic        ovf;
    logic        err;
    int          due;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N && DONE) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done cyc %0d got 1 expected 0",
                 cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.tag, "_bin"}, int'(BIN), int'(e.bin));
        chk({e.tag, "_ovf"}, int'(OVF), int'(e.ovf));
        chk({e.tag, "_err"}, int'(ERR), int'(e.err));
        chk({e.tag, "_lat"}, cyc, e.due);
      end
    end
  end

  task automatic run(input logic [15:0] bcd,
                     input int bin, input bit ovf,
                     input bit err, input int lat,
                     input bit disturb, input string tag);
    exp_t e;
    int   busy;
    bit   seen;
    @(negedge CLK);
    BCDIN = bcd;
    START = 1'b1;
    e.bin = 11'(bin);
    e.ovf = ovf;
    e.err = err;
    e.due = cyc + 1 + lat;
    e.tag = tag;
    q.push_back(e);
    busy = 0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge CLK);
      if (k == 0) START = 1'b0;
      if (disturb) begin
        if (k == 4) begin START = 1'b1; BCDIN = 16'h9999; end
        if (k == 5) START = 1'b0;
        if (k == 9) begin START = 1'b1; BCDIN = 16'h0777; end
        if (k == 10) START = 1'b0;
      end
      if (BUSY) busy++;
      if (DONE) seen = 1'b1;
    end
    if (!seen) begin
      $display("FAIL %s_timeout got 0 expected 1", tag);
      q.delete();
    end
    chk({tag, "_seen"}, int'(seen), 1);
    chk({tag, "_busy"}, busy, lat);
    @(negedge CLK);
    chk({tag, "_done_pulse"}, int'(DONE), 0);
    chk({tag, "_qempty"}, q.size(), 0);
  endtask

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    BCDIN = 16'h0000;
    #1;
    chk("rst_bin",  int'(BIN),  0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_ovf",  int'(OVF),  0);
    chk("rst_err",  int'(ERR),  0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    run(16'h1234, 1234, 0, 0, 17, 0, "v1234");
    run(16'h2047, 2047, 0, 0, 17, 0, "v2047");
    run(16'h2048, 2047, 1, 0, 17, 0, "v2048");
    run(16'h9999, 2047, 1, 0, 17, 0, "v9999");
    run(16'h0000,    0, 0, 0, 17, 0, "v0000");
    run(16'h0009,    9, 0, 0, 17, 0, "v0009");
    run(16'h12A4,    0, 0, 1,  1, 0, "v12A4");
    run(16'h0500,  500, 0, 0, 17, 0, "v0500");
    run(16'h0815,  815, 0, 0, 17, 1, "vdist");

    // Abort a conversion with an asynchronous reset.
    @(negedge CLK);
    BCDIN = 16'h1234;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (7) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_bin",  int'(BIN),  0);
    chk("arst_done", int'(DONE), 0);
    chk("arst_busy", int'(BUSY), 0);
    chk("arst_ovf",  int'(OVF),  0);
    chk("arst_err",  int'(ERR),  0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (25) @(negedge CLK);
    chk("arst_idle", int'(BUSY), 0);

    run(16'h0042,   42, 0, 0, 17, 0, "v0042");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_conv.md
Name: bcd_to_bin_conv

Overview:
Sequential BCD-to-binary converter using reverse double-dabble (shift right, then subtract 3 from each nibble that is 8 or more). It is the inverse of the display path's binary-to-BCD conversion. It turns packed decimal digits (debug switches, UART-entered setpoints) into the binary values the servo/SPI logic consumes. It uses a START/DONE handshake and takes one shift per clock.

Parameters:
NDIG, 4, number of packed BCD digits; supported range 1..4.
OUT_W, 11, width of the binary result; larger results saturate to 2^OUT_W-1.

Ports:
CLK  input  1  system clock, 100 MHz.
RST_N  input  1  asynchronous active-low reset.
START  input  1  conversion request; sampled only in IDLE.
BCDIN  input  4*NDIG  packed BCD, most significant digit in the top nibble.
BIN  output  OUT_W  registered binary result.
DONE  output  1  one-cycle pulse when BIN, OVF and ERR are valid.
BUSY  output  1  high whenever state is not IDLE.
OVF  output  1  high when the true value exceeded 2^OUT_W-1 and BIN is saturated.
ERR  output  1  high when any input nibble was greater than 9.

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous, active-low.
  - While RST_N=0: state=IDLE; BIN=0, DONE=0, BUSY=0, OVF=0, ERR=0; internal registers cleared.
  - A reset mid-conversion aborts the conversion with no DONE pulse.
- Internal registers:
  - Shift register SR, width 8*NDIG: upper half holds BCD, lower half accumulates binary.
  - Iteration counter ITC, width 5.
- State machine (states IDLE, CONV, FIN):
  - IDLE: on an edge with START=1:
    - Latch BCDIN into the upper half of SR; clear the lower half; ITC=0.
    - If any nibble is greater than 9: set the internal error flag, go to FIN (no conversion).
    - Otherwise: clear the error flag, go to CONV.
  - CONV, each edge:
    - SR is logically shifted right by 1.
    - Then each BCD nibble of the shifted upper half that is 8 or more has 3 subtracted. The correction applies per nibble and in parallel, with no carries between nibbles.
    - ITC increments. After the 4*NDIG-th shift, go to FIN.
  - FIN, one edge:
    - Load BIN, OVF and ERR; assert DONE for exactly one cycle; return to IDLE.
    - Error case: BIN=0, OVF=0, ERR=1.
    - Normal case: ERR=0. If the lower half of SR exceeds 2^OUT_W-1, then BIN=2^OUT_W-1 and OVF=1; otherwise BIN takes the lower OUT_W bits of SR and OVF=0.
- Latency from the START-sampling edge to DONE high:
  - Valid input: 4*NDIG+1 cycles (17 for NDIG=4).
  - Invalid input: 1 cycle.
- Outputs between conversions:
  - BIN, OVF and ERR hold their values until the next FIN.
  - DONE is a single pulse; it is never held.
- BUSY is asserted from the START edge through the FIN cycle. It is low in the cycle DONE drops.
- START while BUSY=1 is ignored: no queueing, no restart.
- START held high continuously: a new conversion begins on the first IDLE edge after FIN, so there is one IDLE cycle between back-to-back conversions.
- BCDIN is sampled only at the START edge; later changes to BCDIN have no effect on the conversion in progress.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
1. Reset, then BCDIN=16'h1234 with a 1-cycle START -> DONE exactly 17 cycles later; BIN=11'd1234 (0x4D2); OVF=0; ERR=0; BUSY high for 17 cycles.
2. BCDIN=16'h2047 -> BIN=0x7FF, OVF=0. BCDIN=16'h2048 -> BIN=0x7FF, OVF=1. BCDIN=16'h9999 -> BIN=0x7FF, OVF=1.
3. BCDIN=16'h0000 -> BIN=0, OVF=0. BCDIN=16'h0009 -> BIN=9. Check that a previous BIN value is fully replaced each time.
4. BCDIN=16'h12A4 -> DONE 1 cycle after START; ERR=1; BIN=0. A following valid conversion of 16'h0500 -> ERR=0, BIN=500.
5. Pulse START again at cycles 5 and 10 of a conversion, and change BCDIN mid-conversion -> a single DONE at cycle 17 with the originally latched result.
6. Drive RST_N low at cycle 8 of a conversion -> all outputs 0 immediately (asynchronous), no DONE. After release, converting 16'h0042 gives BIN=42.
